// File: rtl/flopenr_pipe.sv
// flopenr_pipe: STAGES-deep chain of WIDTH-bit enable/reset registers with
// valid/ready flow control. Stalls hold data, bubbles collapse, flush clears.
// Optional feature macro: FLOPENR_PIPE_OCCUPANCY_EN adds occupancy/full ports.
module flopenr_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FLOPENR_PIPE_OCCUPANCY_EN
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic             full,
`endif
  output logic [WIDTH-1:0] out_data
);

  generate
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("flopenr_pipe: STAGES must be in 1..8");
    end
  endgenerate

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] adv;
  logic              in_xfer;

  // Stage k may advance when downstream drains or any stage at/after k is empty.
  // Computed as a running AND so no signal feeds back into itself.
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    adv   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_v  = all_v & v[k];
      adv[k] = out_ready | ~all_v;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Chain update: reset/flush clear everything, otherwise advancing stages load
  // from upstream; data only loads on a valid slot so bubbles do not toggle d.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          if (k == 0) begin
            v[0] <= in_xfer;
            if (in_xfer) d[0] <= in_data;
          end else begin
            v[k] <= v[k-1];
            if (v[k-1]) d[k] <= d[k-1];
          end
        end
      end
    end
  end

`ifdef FLOPENR_PIPE_OCCUPANCY_EN
  localparam int unsigned OW = $clog2(STAGES + 1);
  logic out_xfer;
  assign out_xfer = out_valid & out_ready;
  assign full     = (occupancy == OW'(STAGES));

  // Occupancy tracks popcount(v): words enter only at stage 0 and leave only
  // from the last stage, so increment/decrement on the two transfers suffices.
  always_ff @(posedge clk) begin
    if (reset || flush) occupancy <= '0;
    else occupancy <= occupancy + OW'(in_xfer) - OW'(out_xfer);
  end
`endif

endmodule

// File: tb/tb_flopenr_pipe.sv
// Directed bench for flopenr_pipe with WIDTH=8, STAGES=2, RESET_VAL=0.
module tb_flopenr_pipe;
  logic       clk = 1'b0;
  logic       reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
`ifdef FLOPENR_PIPE_OCCUPANCY_EN
  logic [1:0] occupancy;
  logic       full;
`endif
  int total = 0;
  int bad   = 0;

  flopenr_pipe #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FLOPENR_PIPE_OCCUPANCY_EN
    .occupancy(occupancy), .full(full),
`endif
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 1);
`ifdef FLOPENR_PIPE_OCCUPANCY_EN
    chk("rst_occupancy", 32'(occupancy), 0);
`endif
    reset = 1'b0; in_valid = 1'b0;

    // streaming 01..10, two-cycle latency, one word per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 16);
      in_data  = 8'(i + 1);
      #1;
      chk("stream_in_ready", 32'(in_ready), 1);
      chk("stream_out_valid", 32'(out_valid), 32'((i >= 2) && (i < 18)));
      if (i >= 2 && i < 18) chk("stream_out_data", 32'(out_data), 32'(i - 1));
      tick();
    end
    in_valid = 1'b0;

    // back-pressure fill
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; #1;
    chk("bp_acc11", 32'(in_ready), 1);
    tick();
    in_data = 8'h22; #1;
    chk("bp_acc22", 32'(in_ready), 1);
    tick();
    in_data = 8'h33; #1;
    chk("bp_full_in_ready", 32'(in_ready), 0);
    chk("bp_full_out", 32'(out_data), 32'h11);
`ifdef FLOPENR_PIPE_OCCUPANCY_EN
    chk("bp_occupancy", 32'(occupancy), 2);
    chk("bp_full_flag", 32'(full), 1);
`endif
    tick();
    chk("bp_hold_in_ready", 32'(in_ready), 0);
    chk("bp_hold_out", 32'(out_data), 32'h11);
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    chk("bp_release_valid", 32'(out_valid), 1);
    tick();
    in_valid = 1'b0; #1;
    chk("bp_out22", 32'(out_data), 32'h22);
    tick();
    chk("bp_out33_valid", 32'(out_valid), 1);
    chk("bp_out33", 32'(out_data), 32'h33);
    tick();
    chk("bp_empty", 32'(out_valid), 0);

    // bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'h55; #1;
    chk("bub_acc55", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; #1;
    chk("bub_in_ready", 32'(in_ready), 0);
    chk("bub_out44", 32'(out_data), 32'h44);
`ifdef FLOPENR_PIPE_OCCUPANCY_EN
    chk("bub_occupancy", 32'(occupancy), 2);
`endif
    out_ready = 1'b1;
    tick();
    chk("bub_out55_valid", 32'(out_valid), 1);
    chk("bub_out55", 32'(out_data), 32'h55);
    tick();
    chk("bub_empty", 32'(out_valid), 0);

    // flush with a full chain
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h66; tick();
    in_data = 8'h77; tick();
    chk("fl_pre_valid", 32'(out_valid), 1);
    flush = 1'b1; in_data = 8'h88; #1;
    chk("fl_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_out_data", 32'(out_data), 32'h00);
`ifdef FLOPENR_PIPE_OCCUPANCY_EN
    chk("fl_occupancy", 32'(occupancy), 0);
`endif
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_88_dropped", 32'(out_valid), 0);

    // reset mid-stream
    in_valid = 1'b1; in_data = 8'hA0; tick();
    in_data = 8'hA1; tick();
    chk("mr_pre_valid", 32'(out_valid), 1);
    reset = 1'b1; in_data = 8'hA2; tick();
    reset = 1'b0; in_data = 8'hB0; #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; #1;
    chk("mr_lat1", 32'(out_valid), 0);
    tick();
    chk("mr_lat2_valid", 32'(out_valid), 1);
    chk("mr_lat2_data", 32'(out_data), 32'hB0);
    tick();
    chk("mr_drained", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
